// File: rtl/xga_timing_pkg.sv
// ============================================================================
// Package : xga_timing_pkg
// Brief   : Default 1024x768@60 raster constants, counter types and FSM states
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xga_timing_pkg;

   localparam int c_h_active = 1024;
   localparam int c_h_fp     = 24;
   localparam int c_h_sync   = 136;
   localparam int c_h_bp     = 160;
   localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

   localparam int c_v_active = 768;
   localparam int c_v_fp     = 3;
   localparam int c_v_sync   = 6;
   localparam int c_v_bp     = 29;
   localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

   // Shared with the mirrored frame-buffer address stage
   typedef logic [10:0] hcount_t;
   typedef logic [9:0]  vcount_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage : xga_timing_pkg

`default_nettype wire

// File: rtl/xga_timing_gen.sv
// ============================================================================
// Module  : xga_timing_gen
// Brief   : Free-running raster timing generator with whole-frame start/stop
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xga_timing_gen
   import xga_timing_pkg::*;
#(
   parameter int H_ACTIVE = c_h_active,
   parameter int H_FP     = c_h_fp,
   parameter int H_SYNC   = c_h_sync,
   parameter int H_BP     = c_h_bp,
   parameter int V_ACTIVE = c_v_active,
   parameter int V_FP     = c_v_fp,
   parameter int V_SYNC   = c_v_sync,
   parameter int V_BP     = c_v_bp,
   parameter int FC_WIDTH = 6
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                enable_in,
   output logic [10:0]         hcount_out,
   output logic [9:0]          vcount_out,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                blank_out,
   output logic                new_frame_out,
   output logic [FC_WIDTH-1:0] frame_count_out,
   output logic                running_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 2048) begin : g_h_total_check
      $error("H_TOTAL does not fit the 11-bit horizontal counter");
   end
   if (V_TOTAL > 1024) begin : g_v_total_check
      $error("V_TOTAL does not fit the 10-bit vertical counter");
   end

   localparam hcount_t c_h_last     = hcount_t'(H_TOTAL - 1);
   localparam vcount_t c_v_last     = vcount_t'(V_TOTAL - 1);
   localparam hcount_t c_h_vis      = hcount_t'(H_ACTIVE);
   localparam vcount_t c_v_vis      = vcount_t'(V_ACTIVE);
   localparam hcount_t c_hs_first   = hcount_t'(H_ACTIVE + H_FP);
   localparam hcount_t c_hs_last    = hcount_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam vcount_t c_vs_first   = vcount_t'(V_ACTIVE + V_FP);
   localparam vcount_t c_vs_last    = vcount_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   state_t                r_state;
   hcount_t               r_hcount;
   vcount_t               r_vcount;
   logic                  r_hsync;
   logic                  r_vsync;
   logic                  r_blank;
   logic                  r_new_frame;
   logic [FC_WIDTH-1:0]   r_frame_count;
   logic                  r_running;

   state_t                w_state_nxt;
   hcount_t               w_hcount_nxt;
   vcount_t               w_vcount_nxt;
   hcount_t               w_hcount_adv;
   vcount_t               w_vcount_adv;
   logic                  w_last_h;
   logic                  w_last_px;
   logic                  w_frame_start;
   logic                  w_active_nxt;

   // Raster advance as if running; the FSM below picks whether to use it
   always_comb begin
      w_last_h     = (r_hcount == c_h_last);
      w_last_px    = w_last_h && (r_vcount == c_v_last);
      w_hcount_adv = w_last_h ? '0 : r_hcount + 1'b1;
      w_vcount_adv = r_vcount;
      if (w_last_h) begin
         w_vcount_adv = (r_vcount == c_v_last) ? '0 : r_vcount + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_hcount_nxt  = r_hcount;
      w_vcount_nxt  = r_vcount;
      w_frame_start = 1'b0;
      case (r_state)
         IDLE: begin
            w_hcount_nxt = '0;
            w_vcount_nxt = '0;
            if (enable_in) begin
               w_state_nxt   = RUN;
               w_frame_start = 1'b1;
            end
         end
         RUN: begin
            w_hcount_nxt  = w_hcount_adv;
            w_vcount_nxt  = w_vcount_adv;
            w_frame_start = w_last_px;
            if (!enable_in) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (enable_in) begin
               w_state_nxt   = RUN;
               w_hcount_nxt  = w_hcount_adv;
               w_vcount_nxt  = w_vcount_adv;
               w_frame_start = w_last_px;
            end else if (w_last_px) begin
               w_state_nxt  = IDLE;
               w_hcount_nxt = '0;
               w_vcount_nxt = '0;
            end else begin
               w_hcount_nxt = w_hcount_adv;
               w_vcount_nxt = w_vcount_adv;
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_hcount_nxt = '0;
            w_vcount_nxt = '0;
         end
      endcase
      w_active_nxt = (w_state_nxt != IDLE);
   end

   // Decodes use the next-count value so every registered output lines up
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state       <= IDLE;
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_blank       <= 1'b1;
         r_new_frame   <= 1'b0;
         r_frame_count <= '0;
         r_running     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hcount    <= w_hcount_nxt;
         r_vcount    <= w_vcount_nxt;
         r_hsync     <= !(w_active_nxt && (w_hcount_nxt >= c_hs_first)
                                       && (w_hcount_nxt <= c_hs_last));
         r_vsync     <= !(w_active_nxt && (w_vcount_nxt >= c_vs_first)
                                       && (w_vcount_nxt <= c_vs_last));
         r_blank     <= !w_active_nxt || (w_hcount_nxt >= c_h_vis)
                                      || (w_vcount_nxt >= c_v_vis);
         r_new_frame <= w_frame_start;
         r_running   <= w_active_nxt;
         if (w_frame_start) begin
            r_frame_count <= r_frame_count + 1'b1;
         end
      end
   end

   assign hcount_out      = r_hcount;
   assign vcount_out      = r_vcount;
   assign hsync_out       = r_hsync;
   assign vsync_out       = r_vsync;
   assign blank_out       = r_blank;
   assign new_frame_out   = r_new_frame;
   assign frame_count_out = r_frame_count;
   assign running_out     = r_running;

endmodule : xga_timing_gen

`default_nettype wire

// File: tb/tb_xga_timing_gen.sv
// ============================================================================
// Module  : tb_xga_timing_gen
// Brief   : Directed bench on a shrunken raster (25x13) so whole frames are cheap
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xga_timing_gen;

   // Raster: H 16+2+4+3 = 25, hsync low at h 18..21; V 8+1+2+2 = 13, vsync low at v 9..10
   localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
   localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
   localparam int HT = 25, VT = 13, FRAME = 325;
   localparam int FCW = 6;

   logic           clk_in = 1'b0;
   logic           rst_in = 1'b0;
   logic           enable_in = 1'b0;
   logic [10:0]    hcount_out;
   logic [9:0]     vcount_out;
   logic           hsync_out, vsync_out, blank_out, new_frame_out, running_out;
   logic [FCW-1:0] frame_count_out;

   int n_cmp = 0;
   int n_err = 0;
   int hs_low, hs_first, vs_low, vs_first, nf_seen, run_drop;

   xga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .FC_WIDTH(FCW)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .enable_in       (enable_in),
      .hcount_out      (hcount_out),
      .vcount_out      (vcount_out),
      .hsync_out       (hsync_out),
      .vsync_out       (vsync_out),
      .blank_out       (blank_out),
      .new_frame_out   (new_frame_out),
      .frame_count_out (frame_count_out),
      .running_out     (running_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int h, input int v, input logic hs,
                          input logic vs, input logic bl, input logic nf,
                          input int fc, input logic run);
      chk({tag, ".h"},   32'(hcount_out), 32'(h));
      chk({tag, ".v"},   32'(vcount_out), 32'(v));
      chk({tag, ".hs"},  32'(hsync_out), 32'(hs));
      chk({tag, ".vs"},  32'(vsync_out), 32'(vs));
      chk({tag, ".bl"},  32'(blank_out), 32'(bl));
      chk({tag, ".nf"},  32'(new_frame_out), 32'(nf));
      chk({tag, ".fc"},  32'(frame_count_out), 32'(fc));
      chk({tag, ".run"}, 32'(running_out), 32'(run));
   endtask

   initial begin
      // Reset and idle
      tick(3);
      chk_all("reset", 0, 0, 1, 1, 1, 0, 0, 0);
      rst_in = 1'b1;
      tick(2);
      chk_all("idle", 0, 0, 1, 1, 1, 0, 0, 0);

      // Start: first visible pixel with frame pulse
      enable_in = 1'b1;
      tick();
      chk_all("start", 0, 0, 1, 1, 0, 1, 1, 1);

      // First line
      hs_low = 0; hs_first = -1;
      for (int i = 1; i < HT; i++) begin
         tick();
         chk("line.h", 32'(hcount_out), 32'(i));
         chk("line.blank", 32'(blank_out), 32'(i >= HA));
         if (!hsync_out) begin
            if (hs_first < 0) hs_first = int'(hcount_out);
            hs_low++;
         end
      end
      chk("hsync.first", 32'(hs_first), 32'(18));
      chk("hsync.len", 32'(hs_low), 32'(HS));
      tick();
      chk_all("wrap_line", 0, 1, 1, 1, 0, 0, 1, 1);

      // Rest of frame: now at cycle 25 of the frame
      vs_low = 0; vs_first = -1; nf_seen = 0;
      for (int t = HT + 1; t < FRAME; t++) begin
         tick();
         if (!vsync_out) begin
            if (vs_first < 0) vs_first = t;
            vs_low++;
         end
         if (new_frame_out) nf_seen++;
      end
      chk("vsync.first", 32'(vs_first), 32'(9 * HT));
      chk("vsync.len", 32'(vs_low), 32'(VS * HT));
      chk("frame1.no_pulse", 32'(nf_seen), 32'(0));
      tick();
      chk_all("frame2", 0, 0, 1, 1, 0, 1, 2, 1);

      // Drop at (5,3), raise at (10,11): seamless
      tick(3 * HT + 5);
      chk("drop.h", 32'(hcount_out), 32'(5));
      chk("drop.v", 32'(vcount_out), 32'(3));
      enable_in = 1'b0;
      nf_seen = 0; run_drop = 0;
      for (int i = 0; i < 8 * HT + 5; i++) begin
         tick();
         if (new_frame_out) nf_seen++;
         if (!running_out) run_drop++;
      end
      chk("raise.h", 32'(hcount_out), 32'(10));
      chk("raise.v", 32'(vcount_out), 32'(11));
      enable_in = 1'b1;
      for (int i = 0; i < FRAME - (11 * HT + 10) - 1; i++) begin
         tick();
         if (new_frame_out) nf_seen++;
         if (!running_out) run_drop++;
      end
      chk("resume.no_pulse", 32'(nf_seen), 32'(0));
      chk("resume.running", 32'(run_drop), 32'(0));
      tick();
      chk_all("frame3", 0, 0, 1, 1, 0, 1, 3, 1);

      // Drop at (5,3) and hold low: drain to idle
      tick(3 * HT + 5);
      enable_in = 1'b0;
      tick(FRAME - 1 - (3 * HT + 5));
      chk_all("drain_last", HT - 1, VT - 1, 1, 1, 1, 0, 3, 1);
      tick();
      chk_all("drained", 0, 0, 1, 1, 1, 0, 3, 0);
      tick(4);
      chk_all("idle2", 0, 0, 1, 1, 1, 0, 3, 0);

      // Drain with enable returning on the final edge: next frame starts
      enable_in = 1'b1;
      tick();
      chk_all("start4", 0, 0, 1, 1, 0, 1, 4, 1);
      enable_in = 1'b0;
      tick(FRAME - 1);
      chk_all("last_px", HT - 1, VT - 1, 1, 1, 1, 0, 4, 1);
      enable_in = 1'b1;
      tick();
      chk_all("rescue", 0, 0, 1, 1, 0, 1, 5, 1);

      // Mid-frame reset at (7,4) aborts immediately
      tick(4 * HT + 7);
      chk("prerst.h", 32'(hcount_out), 32'(7));
      chk("prerst.hs", 32'(hsync_out), 32'(1));
      rst_in = 1'b0;
      tick();
      chk_all("midrst", 0, 0, 1, 1, 1, 0, 0, 0);
      rst_in = 1'b1;

      // Frame counter wrap 63 -> 0
      tick();
      chk_all("restart", 0, 0, 1, 1, 0, 1, 1, 1);
      tick(62 * FRAME);
      chk_all("fc63", 0, 0, 1, 1, 0, 1, 63, 1);
      tick(FRAME);
      chk_all("fc_wrap", 0, 0, 1, 1, 0, 1, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_xga_timing_gen

`default_nettype wire

// File: doc/xga_timing_gen.md
Name: xga_timing_gen

Overview:
- Free-running 1024x768 @ 60 Hz (65 MHz pixel clock) raster timing generator.
- Sits directly upstream of the mirrored frame-buffer address stage, which consumes hcount_out/vcount_out.
- Also drives the VGA sync pins and blanking for the display output path.
- Adds a start/stop control FSM so the display path only ever sees whole frames, plus a frame-start pulse and frame counter for the capture/draw logic.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width (clocks)
- H_BP, 160, horizontal back porch (clocks)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- FC_WIDTH, 6, frame counter width

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous, active-low reset (0 = reset)
- enable_in  input  1  level request to run the raster
- hcount_out  output  11  horizontal position, 0..H_TOTAL-1
- vcount_out  output  10  vertical position, 0..V_TOTAL-1
- hsync_out  output  1  horizontal sync, active low
- vsync_out  output  1  vertical sync, active low
- blank_out  output  1  1 = outside active area, or generator not running
- new_frame_out  output  1  one-cycle pulse at frame start
- frame_count_out  output  FC_WIDTH  count of frames started, wraps
- running_out  output  1  1 when the FSM is in RUN or DRAIN

Behaviour:
- Derived constants: H_TOTAL = sum of the H parameters (1344 at defaults); V_TOTAL = sum of the V parameters (806 at defaults).
- All outputs are registered. Syncs, blank and new_frame are decoded from the next-count value, so every output describes the same (hcount_out, vcount_out) in the same cycle.
- Reset (rst_in=0 on a clock edge) forces: state IDLE, hcount 0, vcount 0, hsync 1, vsync 1, blank 1, new_frame 0, frame_count 0, running 0. Reset asserted mid-frame aborts immediately; there is no drain.
- FSM states:
  - IDLE: counters held at (0,0), syncs inactive, blank 1.
  - RUN: counting.
  - DRAIN: counting; the frame ends after the current one.
- IDLE -> RUN: on any edge where enable_in=1. The next cycle presents (0,0), blank 0, new_frame 1, and frame_count increments.
- RUN: hcount increments each clock. At H_TOTAL-1, hcount wraps to 0 and vcount increments. At (H_TOTAL-1, V_TOTAL-1) both wrap to (0,0), new_frame pulses and frame_count increments (wraps 2^FC_WIDTH-1 -> 0).
- RUN -> DRAIN: enable_in=0 at any position. Counting continues unchanged.
- DRAIN -> RUN: enable_in=1 before the last pixel. Seamless; no extra pulse.
- DRAIN at last pixel (H_TOTAL-1, V_TOTAL-1):
  - Moves to IDLE, with outputs at IDLE values the next cycle.
  - No new_frame pulse and no frame_count increment.
  - If enable_in=1 on that same edge, the DRAIN -> RUN rule takes priority and the next frame starts normally.
- Decodes (at defaults):
  - hsync low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 1048..1183.
  - vsync low for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = 771..776, for the full line width.
  - blank = (hcount >= H_ACTIVE) or (vcount >= V_ACTIVE) or IDLE.
- running_out = 1 in RUN or DRAIN.
- Counter widths are fixed at 11/10 bits. Elaboration asserts H_TOTAL <= 2048 and V_TOTAL <= 1024.

Decomposition:
- Shared package xga_timing_pkg holds:
  - default timing constants and the derived H_TOTAL/V_TOTAL;
  - the typedef enum logic [1:0] {IDLE, RUN, DRAIN} for the FSM state;
  - the hcount_t (11 bit) and vcount_t (10 bit) typedefs, also used by the mirror/address stage.
- Single module. The counter and decode logic are too small to justify a sub-module.

Test Plan:
- Reset, then enable_in=1 -> the cycle after the enabling edge shows hcount=0, vcount=0, new_frame=1, frame_count=1, blank=0; hsync/vsync=1 throughout IDLE.
- Run one line -> blank rises at hcount=1024; hsync low for exactly 136 cycles starting at hcount=1048; hcount wraps 1343 -> 0 with vcount 0 -> 1.
- Run a full frame -> vsync low for lines 771..776 (6*1344 = 8064 cycles); at 1344*806 = 1,083,264 cycles after start, new_frame pulses again and frame_count=2.
- Drop enable_in at (500,300), raise at (10,700) -> no gap; counting continues and the next frame starts normally with a pulse.
- Drop enable_in at (500,300), hold low -> after (1343,805) the generator goes IDLE: counts 0, blank 1, no new_frame pulse, frame_count unchanged, running_out=0.
- Assert rst_in=0 at (700,400) for 1 cycle -> next cycle all outputs at reset values; the wrap test from frame_count 63 -> 0 passes via forced long run.
